// File: rtl/magnitude_pkg.sv
// magnitude_pkg: shared widths, pipeline latency and {imag,real} sample packing.
package magnitude_pkg;
    localparam int PIPE_LAT = 3;
    localparam int DEF_DATA_W = 16;

    function automatic int mag_w(input int data_w);
        return 2 * data_w;
    endfunction

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] im;
        logic signed [DEF_DATA_W-1:0] re;
    } cplx16_t;
endpackage

// File: rtl/magnitude_avg_stream_if.sv
// magnitude_avg_stream_if: AXI4-Stream data/valid/ready/last bundle.
interface magnitude_avg_stream_if #(parameter int W = 32) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master(output tdata, tvalid, tlast, input tready);
    modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/mag_sq_core.sv
// mag_sq_core: stall-enabled |re|^2+|im|^2 datapath; S1 registers abs, S2 registers the sum.
module mag_sq_core import magnitude_pkg::*; #(
    parameter int DATA_W = 16
) (
    input  logic                        clk,
    input  logic                        en,
    input  logic signed [DATA_W-1:0]    re_i,
    input  logic signed [DATA_W-1:0]    im_i,
    output logic [mag_w(DATA_W)-1:0]    sum_o
);
    localparam int MW = mag_w(DATA_W);

    logic [DATA_W:0] abs_re_q, abs_im_q;
    logic [MW-1:0]   sum_q, sum_d;

    // one extra bit so -2^(W-1) becomes +2^(W-1) without wrapping
    function automatic logic [DATA_W:0] abs_f(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W:0] xe = {x[DATA_W-1], x};
        return xe[DATA_W] ? -xe : xe;
    endfunction

    assign sum_d = MW'(abs_re_q) * MW'(abs_re_q) + MW'(abs_im_q) * MW'(abs_im_q);
    assign sum_o = sum_q;

    always_ff @(posedge clk)
        if (en) begin
            abs_re_q <= abs_f(re_i);
            abs_im_q <= abs_f(im_i);
            sum_q    <= sum_d;
        end
endmodule

// File: rtl/magnitude_avg_stream.sv
// magnitude_avg_stream: streaming |X|^2 with optional per-bin averaging over 2^AVG_LOG2 frames.
module magnitude_avg_stream import magnitude_pkg::*; #(
    parameter int DATA_W   = 16,
    parameter int OUT_W    = 32,
    parameter int FFT_LEN  = 1024,
    parameter int AVG_LOG2 = 3
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    avg_en,
    magnitude_avg_stream_if.slave   s_axis,
    magnitude_avg_stream_if.master  m_axis,
    output logic                    frame_err
);
    localparam int MW = mag_w(DATA_W);
    localparam int BW = $clog2(FFT_LEN);
    localparam int FW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int AW = OUT_W + AVG_LOG2;

    logic [1:0]       rst_q;
    logic             rst, adv, acc, emit;
    logic [BW-1:0]    bin_q, bin_d, bin1_q, bin2_q;
    logic [FW-1:0]    frm_q, frm_d;
    logic             mode_q, mode_d, err_q, err_d;
    logic             v1_q, v2_q, v3_q, mode1_q, mode2_q;
    logic             first1_q, first2_q, lastf1_q, lastf2_q, last_q;
    logic [OUT_W-1:0] data_q, res;
    logic [MW-1:0]    sum;

    assign rst = rst_q[1];
    assign adv = ~v3_q | m_axis.tready;
    assign acc = s_axis.tvalid & s_axis.tready;
    assign s_axis.tready = adv & ~rst;
    assign m_axis.tvalid = v3_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tlast  = last_q;
    assign frame_err     = err_q;

    mag_sq_core #(.DATA_W(DATA_W)) u_core (
        .clk  (aclk),
        .en   (adv),
        .re_i (s_axis.tdata[DATA_W-1:0]),
        .im_i (s_axis.tdata[2*DATA_W-1:DATA_W]),
        .sum_o(sum)
    );

    // mode is latched only on the first beat of a frame
    always_comb begin
        mode_d = (acc & bin_q == '0) ? avg_en & (AVG_LOG2 > 0) : mode_q;
        bin_d  = acc ? ((s_axis.tlast | bin_q == BW'(FFT_LEN - 1)) ? '0 : bin_q + 1'b1) : bin_q;
        err_d  = err_q | (acc & (s_axis.tlast ^ (bin_q == BW'(FFT_LEN - 1))));
        frm_d  = ~acc ? frm_q : ~mode_d ? '0 : s_axis.tlast ? frm_q + 1'b1 : frm_q;
    end

    always_ff @(posedge aclk or posedge areset)
        if (areset) rst_q <= 2'b11;
        else        rst_q <= {rst_q[0], 1'b0};

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            {bin_q, bin1_q, bin2_q, frm_q} <= '0;
            {mode_q, err_q, v1_q, v2_q, v3_q, mode1_q, mode2_q} <= '0;
            {first1_q, first2_q, lastf1_q, lastf2_q, last_q} <= '0;
            data_q <= '0;
        end else begin
            bin_q  <= bin_d;
            frm_q  <= frm_d;
            mode_q <= mode_d;
            err_q  <= err_d;
            if (adv) begin
                v1_q     <= acc;
                bin1_q   <= bin_q;
                mode1_q  <= mode_d;
                first1_q <= frm_q == '0;
                lastf1_q <= frm_q == FW'((1 << AVG_LOG2) - 1);
                v2_q     <= v1_q;
                bin2_q   <= bin1_q;
                mode2_q  <= mode1_q;
                first2_q <= first1_q;
                lastf2_q <= lastf1_q;
                v3_q     <= emit;
                data_q   <= res;
                last_q   <= bin2_q == BW'(FFT_LEN - 1);
            end
        end
    end

    if (AVG_LOG2 > 0) begin : g_avg
        logic [AW-1:0] ram [FFT_LEN];
        logic [AW-1:0] rd_q, sum_acc;
        assign sum_acc = (first2_q ? '0 : rd_q) + AW'(sum);
        assign res  = mode2_q ? sum_acc[AVG_LOG2 +: OUT_W] : OUT_W'(sum);
        assign emit = v2_q & (~mode2_q | lastf2_q);
        // read issued from S1 so the stored partial sum lines up with S2
        always_ff @(posedge aclk)
            if (adv) begin
                rd_q <= ram[bin1_q];
                if (v2_q & mode2_q) ram[bin2_q] <= sum_acc;
            end
    end else begin : g_pass
        assign res  = OUT_W'(sum);
        assign emit = v2_q;
    end
endmodule
